// File: rtl/avalon_host_pkg.sv
// Shared types and helpers for the Avalon host master: FSM state encoding
// and the width of the read-timeout counter.
package avalon_host_pkg;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT,
    RESP
  } state_t;

  // A TIMEOUT of 2 still needs one bit to hold counts 0 and 1.
  function automatic int timer_width(input int timeout);
    return ($clog2(timeout) < 1) ? 1 : $clog2(timeout);
  endfunction

endpackage

// File: rtl/avalon_host_timeout.sv
// Read-timeout counter: synchronous clear, count enable, and a terminal-count
// flag at TIMEOUT-1. It stops counting at the terminal count and never wraps.
module avalon_host_timeout
  import avalon_host_pkg::*;
#(
  parameter int TIMEOUT = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  localparam int TW = timer_width(TIMEOUT);

  logic [TW-1:0] count;

  assign expired = (count == TW'(TIMEOUT - 1));

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable && !expired) begin
      count <= count + TW'(1);
    end
  end

endmodule

// File: rtl/avalon_host_master.sv
// Avalon-style initiator: turns one valid/ready command into a single
// read/write strobe and returns one response, with a read timeout.
module avalon_host_master
  import avalon_host_pkg::*;
#(
  parameter int ADDRWIDTH = 8,
  parameter int DATAWIDTH = 32,
  parameter int TIMEOUT   = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic                 cmd_write,
  input  logic [ADDRWIDTH-1:0] cmd_address,
  input  logic [DATAWIDTH-1:0] cmd_data,
  output logic                 rsp_valid,
  input  logic                 rsp_ready,
  output logic [DATAWIDTH-1:0] rsp_data,
  output logic                 rsp_error,
  output logic                 read,
  output logic                 write,
  output logic [ADDRWIDTH-1:0] address,
  output logic [DATAWIDTH-1:0] data_out,
  input  logic                 read_valid,
  input  logic [DATAWIDTH-1:0] data_in,
  output logic                 stray_read
);

  state_t state;
  logic   cap_write;
  logic   timer_expired;

  // The timer is zeroed while the strobe is out, so WAIT always starts at 0.
  avalon_host_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (state == ISSUE),
    .enable (state == WAIT),
    .expired(timer_expired)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      cap_write  <= 1'b0;
      cmd_ready  <= 1'b1;
      read       <= 1'b0;
      write      <= 1'b0;
      address    <= '0;
      data_out   <= '0;
      rsp_valid  <= 1'b0;
      rsp_data   <= '0;
      rsp_error  <= 1'b0;
      stray_read <= 1'b0;
    end else begin
      // NOTE: strobes default low every cycle so they can only ever be one-cycle pulses.
      read  <= 1'b0;
      write <= 1'b0;

      // A reply arriving while no read is pending (e.g. after a timeout) is dropped but flagged.
      if (read_valid && state != WAIT) begin
        stray_read <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (cmd_valid) begin
            cap_write <= cmd_write;
            address   <= cmd_address;
            data_out  <= cmd_data;
            cmd_ready <= 1'b0;
            write     <= cmd_write;
            read      <= !cmd_write;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          if (cap_write) begin
            rsp_data  <= '0;
            rsp_error <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else begin
            state <= WAIT;
          end
        end
        WAIT: begin
          if (read_valid) begin
            rsp_data  <= data_in;
            rsp_error <= 1'b0;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end else if (timer_expired) begin
            rsp_data  <= '0;
            rsp_error <= 1'b1;
            rsp_valid <= 1'b1;
            state     <= RESP;
          end
        end
        RESP: begin
          if (rsp_ready) begin
            rsp_valid <= 1'b0;
            cmd_ready <= 1'b1;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
